// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the picoMIPS sequential ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_MUL = 2'b01,
    ALU_DIV = 2'b10,
    ALU_NOP = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } alu_state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative signed MUL/DIV datapath: magnitudes go through a shared 2N-bit shift
// register and N+1-bit adder, one bit per step, with a sign fix-up on the final step.
module seq_muldiv_core #(
  parameter int N = 8,
  localparam int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         last,
  output logic [N-1:0] lo,
  output logic [N-1:0] hi,
  output logic         div0
);

  logic [2*N-1:0] p, p_nxt, prod;
  logic [N-1:0]   m, a_mag, b_mag, q, r;
  logic [CW-1:0]  cnt;
  logic           div_q, neg_lo, neg_hi;
  logic [N:0]     x, y, sum;
  logic           cin;

  assign a_mag = a[N-1] ? -a : a;
  assign b_mag = b[N-1] ? -b : b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p      <= '0;
      m      <= '0;
      cnt    <= '0;
      div_q  <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
    end else if (load) begin
      p      <= {{N{1'b0}}, b_mag};
      m      <= a_mag;
      cnt    <= CW'(N);
      div_q  <= is_div;
      neg_lo <= (a[N-1] ^ b[N-1]) && (a != '0);
      neg_hi <= is_div ? b[N-1] : (a[N-1] ^ b[N-1]);
      div0   <= is_div && (a == '0);
    end else if (step) begin
      p   <= p_nxt;
      cnt <= cnt - CW'(1);
    end
  end

  // MUL adds the multiplicand when the LSB is set; DIV trial-subtracts the divisor
  // from the remainder shifted left with the next dividend bit.
  always_comb begin
    x   = {1'b0, p[2*N-1:N]};
    y   = p[0] ? {1'b0, m} : '0;
    cin = 1'b0;
    if (div_q) begin
      x   = {p[2*N-1:N], p[N-1]};
      y   = ~{1'b0, m};
      cin = 1'b1;
    end
  end

  assign sum = x + y + {{N{1'b0}}, cin};

  always_comb begin
    p_nxt = {sum, p[N-1:1]};
    if (div_q)
      p_nxt = sum[N] ? {x[N-1:0], p[N-2:0], 1'b0} : {sum[N-1:0], p[N-2:0], 1'b1};
  end

  // last marks the step that takes the counter to zero; results below are valid then.
  assign last = (cnt == CW'(1));

  assign prod = neg_lo ? -p_nxt : p_nxt;
  assign q    = p_nxt[N-1:0];
  assign r    = p_nxt[2*N-1:N];

  always_comb begin
    lo = prod[N-1:0];
    hi = prod[2*N-1:N];
    if (div_q) begin
      lo = div0 ? '1 : (neg_lo ? -q : q);
      hi = neg_hi ? -r : r;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle picoMIPS ALU: single-cycle ADD/NOP, iterative signed MUL/DIV,
// with a start/ready/done handshake the controller uses to stall.
module seq_alu
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   ALUfunc,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         div0
);

  alu_state_t   state, state_nxt;
  alu_op_t      op;
  logic         accept, iter_op, load, last;
  logic [N-1:0] core_lo, core_hi;
  logic         core_div0;

  assign op      = alu_op_t'(ALUfunc);
  assign iter_op = (op == ALU_MUL) || (op == ALU_DIV);
  assign accept  = start && ready;
  assign load    = accept && iter_op;

  seq_muldiv_core #(.N(N)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (busy),
    .is_div (op == ALU_DIV),
    .a      (a),
    .b      (b),
    .last   (last),
    .lo     (core_lo),
    .hi     (core_hi),
    .div0   (core_div0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)          state_nxt = iter_op ? CALC : DONE;
        else                state_nxt = IDLE;
      end
      CALC:   if (last)     state_nxt = DONE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b1;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      CALC: begin
        ready = 1'b0;
        busy  = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Outputs only change on the edge entering DONE and hold until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      result_hi <= '0;
      div0      <= 1'b0;
    end else if (accept && !iter_op) begin
      result    <= (op == ALU_ADD) ? a + b : '0;
      result_hi <= '0;
      div0      <= 1'b0;
    end else if (busy && last) begin
      result    <= core_lo;
      result_hi <= core_hi;
      div0      <= core_div0;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed and random checks of seq_alu against an integer-arithmetic reference model.
module tb_seq_alu;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   ALUfunc;
  logic [N-1:0] a, b;
  logic         ready, busy, done, div0;
  logic [N-1:0] result, result_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ALUfunc   (ALUfunc),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .div0      (div0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [N-1:0] ai, input logic [N-1:0] bi,
                                output logic [N-1:0] lo, output logic [N-1:0] hi, output logic z);
    int sa, sb;
    longint pr;
    sa = $signed(ai);
    sb = $signed(bi);
    lo = '0; hi = '0; z = 1'b0;
    case (op)
      2'b00: lo = N'(sa + sb);
      2'b01: begin
        pr = longint'(sa) * longint'(sb);
        lo = pr[N-1:0];
        hi = pr[2*N-1:N];
      end
      2'b10: begin
        if (sa == 0) begin
          lo = '1; hi = bi; z = 1'b1;
        end else begin
          lo = N'(sb / sa);
          hi = N'(sb % sa);
        end
      end
      default: ;
    endcase
  endfunction

  // Issue one op (accepted at the next edge), optionally poke start mid-iteration,
  // then check latency, busy/ready and results against the model.
  task automatic run(input logic [1:0] op, input logic [N-1:0] av, input logic [N-1:0] bv,
                     input bit poke, input string tag);
    logic [N-1:0] elo, ehi;
    logic         ez;
    int           lat, exp_lat;
    model(op, av, bv, elo, ehi, ez);
    exp_lat = (op == 2'b01 || op == 2'b10) ? N + 1 : 1;
    @(negedge clk);
    start = 1'b1; ALUfunc = op; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = N'($urandom); b = N'($urandom); ALUfunc = 2'($urandom);
    lat = 1;
    if (exp_lat > 1) chk({tag, ".busy"}, {busy, ready}, 2'b10);
    while (!done && lat < 40) begin
      start = (poke && lat == 3);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, {result_hi, result}, {ehi, elo});
    chk({tag, ".div0"}, div0, ez);
  endtask

  initial begin
    logic [1:0] rop;
    bit seen;
    reset = 1'b1; start = 1'b0; ALUfunc = 2'b00; a = '0; b = '0;
    #12;
    chk("reset", {ready, busy, done, div0, result_hi, result}, {4'b1000, 16'h0000});
    @(negedge clk); reset = 1'b0;

    run(2'b00, 8'd100, 8'd27, 0, "add");
    chk("add.val", result, 8'h7F);
    @(posedge clk); #1;
    chk("done.pulse", {done, ready}, 2'b01);
    run(2'b00, 8'd100, 8'd100, 0, "addwrap");
    run(2'b01, -8'sd3, 8'd7, 0, "mul");
    chk("mul.val", {result_hi, result}, 16'hFFEB);
    run(2'b01, 8'h80, 8'h80, 0, "mulneg");
    chk("mulneg.val", {result_hi, result}, 16'h4000);
    run(2'b10, 8'd2, -8'sd7, 0, "div");
    chk("div.val", {result_hi, result}, 16'hFFFD);
    run(2'b10, 8'hFF, 8'h80, 0, "divovf");
    run(2'b10, 8'd0, 8'd5, 0, "div0");
    chk("div0.val", {div0, result_hi, result}, {1'b1, 16'h05FF});
    run(2'b00, 8'd3, 8'd4, 0, "div0clr");
    run(2'b01, 8'd12, -8'sd5, 1, "poke");
    run(2'b00, 8'd1, 8'd1, 0, "b2b");
    chk("b2b.val", result, 8'h02);
    run(2'b11, 8'd9, 8'd9, 0, "nop");

    // Asynchronous reset partway through a MUL.
    run(2'b01, 8'd7, 8'd9, 0, "premul");
    @(negedge clk);
    start = 1'b1; ALUfunc = 2'b01; a = 8'd5; b = 8'd6;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("midreset", {ready, busy, done, div0, result_hi, result}, {4'b1000, 16'h0000});
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (N + 2) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("nodone", seen, 1'b0);
    run(2'b01, 8'd16, 8'd16, 0, "mul16");
    chk("mul16.val", {result_hi, result}, 16'h0100);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 7) == 0)
        run(rop, 8'd0, N'($urandom), 0, "rndz");
      else
        run(rop, N'($urandom), N'($urandom), i[0], "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
